// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode, control-code and bundle definitions for the decode stage
package decode_stage_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] RW_NONE   = 3'd0;
  localparam logic [2:0] RW_LW     = 3'd3;
  localparam logic [2:0] NOBRANCH  = 3'd0;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_LUI   = 4'd9;
  localparam logic [4:0] ALU_MUL   = 5'b10000;
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        jal;
    logic        jalr;
    logic [2:0]  reg_write;
    logic        mem_to_reg;
    logic [3:0]  mem_write;
    logic        load_npc;
    logic [1:0]  reg_read;
    logic [2:0]  branch_type;
    logic        alu_src1;
    logic [1:0]  alu_src2;
    imm_t        imm_type;
    logic        is_muldiv;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I(+M) instruction decoder with immediate extraction and illegal detection
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int ALU_W    = 4
) (
  input  logic [31:0]      instr,
  output dec_t             d,
  output logic [ALU_W-1:0] alu_ctrl
);
  logic [6:0] op, fn7;
  logic [2:0] fn3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_reg;
  logic is_m, sh_imm, sub_sra, known, bad, wr;
  imm_t it;
  assign op       = instr[6:0];
  assign fn3      = instr[14:12];
  assign fn7      = instr[31:25];
  assign is_lui   = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign is_jal   = op == OP_JAL;
  assign is_jalr  = op == OP_JALR;
  assign is_br    = op == OP_BRANCH;
  assign is_ld    = op == OP_LOAD;
  assign is_st    = op == OP_STORE;
  assign is_imm   = op == OP_IMM;
  assign is_reg   = op == OP_REG;
  assign is_m     = (ENABLE_M != 0) && is_reg && fn7 == 7'h01;
  assign sh_imm   = is_imm && fn3[1:0] == 2'b01;
  assign sub_sra  = (is_reg || (sh_imm && fn3[2])) && fn7 == 7'h20;
  assign known    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_imm | is_reg;
  assign wr       = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_reg;
  assign bad = !known
    || (is_ld && (fn3 == 3'b011 || fn3[2:1] == 2'b11))
    || (is_st && fn3 > 3'b010)
    || (is_br && fn3[2:1] == 2'b01)
    || (is_reg && !(fn7 == 7'h00 || fn7 == 7'h20 || is_m))
    || (is_reg && fn7 == 7'h20 && !(fn3 == 3'b000 || fn3 == 3'b101))
    || (is_imm && fn3 == 3'b001 && fn7 != 7'h00)
    || (is_imm && fn3 == 3'b101 && !(fn7 == 7'h00 || fn7 == 7'h20));
  assign it = (is_lui | is_auipc) ? IMM_U : is_jal ? IMM_J : is_br ? IMM_B : is_st ? IMM_S :
              (is_jalr | is_ld | is_imm) ? IMM_I : IMM_R;
  always_comb begin
    d             = '0;
    d.imm         = it == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
                    it == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                    it == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                    it == IMM_U ? {instr[31:12], 12'b0} :
                    it == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'd0;
    d.rs1         = instr[19:15];
    d.rs2         = instr[24:20];
    d.rd          = instr[11:7];
    d.jal         = is_jal & !bad;
    d.jalr        = is_jalr & !bad;
    d.load_npc    = (is_jal | is_jalr) & !bad;
    d.reg_write   = (bad || !wr || instr[11:7] == 5'd0) ? RW_NONE : is_ld ? fn3 + 3'd1 : RW_LW;
    d.mem_to_reg  = is_ld;
    d.mem_write   = (bad || !is_st) ? 4'b0000 : fn3 == 3'b000 ? 4'b0001 : fn3 == 3'b001 ? 4'b0011 : 4'b1111;
    d.reg_read    = {is_reg | is_imm | is_ld | is_st | is_br | is_jalr, is_reg | is_st | is_br};
    d.branch_type = (is_br && !bad) ? fn3 - 3'd2 : NOBRANCH;
    d.alu_src1    = is_auipc;
    d.alu_src2    = sh_imm ? 2'b01 : (is_reg | is_br) ? 2'b00 : 2'b10;
    d.imm_type    = it;
    d.is_muldiv   = is_m & !bad;
    d.illegal     = bad;
    alu_ctrl      = is_m ? ALU_W'({2'b10, fn3}) : sub_sra ? ALU_W'({2'b01, fn3}) : is_lui ? ALU_W'(ALU_LUI) :
                    (is_reg | is_imm) ? ALU_W'(fn3) : ALU_W'(ALU_ADD);
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with main/skid entries, valid/ready handshake and sequence tagging
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int SEQ_W    = 8,
  localparam int ALU_W   = (ENABLE_M != 0) ? 5 : 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      pc_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             jal,
  output logic             jalr,
  output logic [2:0]       reg_write,
  output logic             mem_to_reg,
  output logic [3:0]       mem_write,
  output logic             load_npc,
  output logic [1:0]       reg_read,
  output logic [2:0]       branch_type,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             alu_src1,
  output logic [1:0]       alu_src2,
  output logic [2:0]       imm_type,
  output logic             is_muldiv,
  output logic             illegal,
  output logic [SEQ_W-1:0] seq_id
);
  typedef struct packed {
    dec_t             d;
    logic [ALU_W-1:0] alu;
    logic [31:0]      pc;
    logic [SEQ_W-1:0] seq;
  } ent_t;
  dec_t dec;
  logic [ALU_W-1:0] alu;
  ent_t main_q, skid_q, new_e;
  logic main_v, skid_v, acc;
  logic [SEQ_W-1:0] seq_q;
  decode_comb #(.ENABLE_M(ENABLE_M), .ALU_W(ALU_W)) u_dec (.instr(instr), .d(dec), .alu_ctrl(alu));
  assign new_e    = {dec, alu, pc, seq_q};
  assign in_ready = !skid_v;
  assign acc      = in_valid & in_ready & !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      seq_q  <= '0;
    end else begin
      if (acc) seq_q <= seq_q + 1'b1;
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (!main_v || out_ready) begin
        main_v <= skid_v | acc;
        skid_v <= 1'b0;
        if (skid_v) main_q <= skid_q;
        else if (acc) main_q <= new_e;
      end else if (acc) begin
        skid_q <= new_e;
        skid_v <= 1'b1;
      end
    end
  end
  assign out_valid   = main_v;
  assign pc_o        = main_q.pc;
  assign seq_id      = main_q.seq;
  assign alu_ctrl    = main_q.alu;
  assign imm_o       = main_q.d.imm;
  assign rs1         = main_q.d.rs1;
  assign rs2         = main_q.d.rs2;
  assign rd          = main_q.d.rd;
  assign jal         = main_q.d.jal;
  assign jalr        = main_q.d.jalr;
  assign reg_write   = main_q.d.reg_write;
  assign mem_to_reg  = main_q.d.mem_to_reg;
  assign mem_write   = main_q.d.mem_write;
  assign load_npc    = main_q.d.load_npc;
  assign reg_read    = main_q.d.reg_read;
  assign branch_type = main_q.d.branch_type;
  assign alu_src1    = main_q.d.alu_src1;
  assign alu_src2    = main_q.d.alu_src2;
  assign imm_type    = main_q.d.imm_type;
  assign is_muldiv   = main_q.d.is_muldiv;
  assign illegal     = main_q.d.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (M enabled and disabled instances)
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0, pc = '0;
  logic in_ready, out_valid, jal, jalr, mem_to_reg, load_npc, alu_src1, is_muldiv, illegal;
  logic [31:0] pc_o, imm_o;
  logic [4:0] rs1, rs2, rd, alu_ctrl;
  logic [2:0] reg_write, branch_type, imm_type;
  logic [3:0] mem_write;
  logic [1:0] reg_read, alu_src2;
  logic [7:0] seq_id;
  logic in_ready0, out_valid0, jal0, jalr0, mem_to_reg0, load_npc0, alu_src10, is_muldiv0, illegal0;
  logic [31:0] pc_o0, imm_o0;
  logic [4:0] rs10, rs20, rd0;
  logic [3:0] alu_ctrl0;
  logic [2:0] reg_write0, branch_type0, imm_type0;
  logic [3:0] mem_write0;
  logic [1:0] reg_read0, alu_src20;
  logic [7:0] seq_id0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decode_stage #(.ENABLE_M(1), .SEQ_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .imm_o(imm_o), .rs1(rs1), .rs2(rs2), .rd(rd),
    .jal(jal), .jalr(jalr), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .load_npc(load_npc), .reg_read(reg_read), .branch_type(branch_type), .alu_ctrl(alu_ctrl),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .imm_type(imm_type), .is_muldiv(is_muldiv),
    .illegal(illegal), .seq_id(seq_id));
  decode_stage #(.ENABLE_M(0), .SEQ_W(8)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0), .instr(instr), .pc(pc),
    .out_valid(out_valid0), .out_ready(out_ready), .pc_o(pc_o0), .imm_o(imm_o0), .rs1(rs10), .rs2(rs20), .rd(rd0),
    .jal(jal0), .jalr(jalr0), .reg_write(reg_write0), .mem_to_reg(mem_to_reg0), .mem_write(mem_write0),
    .load_npc(load_npc0), .reg_read(reg_read0), .branch_type(branch_type0), .alu_ctrl(alu_ctrl0),
    .alu_src1(alu_src10), .alu_src2(alu_src20), .imm_type(imm_type0), .is_muldiv(is_muldiv0),
    .illegal(illegal0), .seq_id(seq_id0));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_seq", seq_id, 0);
    chk("rst_reg_write", reg_write, 0);
    in_valid = 1'b1; instr = 32'h00500093; pc = 32'h100;
    cyc();
    chk("addi_valid", out_valid, 1);
    chk("addi_reg_write", reg_write, 3);
    chk("addi_imm", imm_o, 5);
    chk("addi_src2", alu_src2, 2'b10);
    chk("addi_imm_type", imm_type, 1);
    chk("addi_seq", seq_id, 0);
    chk("addi_pc", pc_o, 32'h100);
    chk("addi_rd", rd, 1);
    instr = 32'h0020A423; pc = 32'h104;
    cyc();
    in_valid = 1'b0;
    chk("sw_mem_write", mem_write, 4'b1111);
    chk("sw_reg_write", reg_write, 0);
    chk("sw_imm", imm_o, 8);
    chk("sw_reg_read", reg_read, 2'b11);
    chk("sw_imm_type", imm_type, 2);
    chk("sw_seq", seq_id, 1);
    cyc();
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093;
    cyc();
    chk("bp1_in_ready", in_ready, 1);
    chk("bp1_seq", seq_id, 2);
    instr = 32'h00200093;
    cyc();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_seq", seq_id, 2);
    instr = 32'h00300093;
    cyc();
    chk("bp3_in_ready", in_ready, 0);
    chk("bp3_imm", imm_o, 1);
    cyc();
    chk("bp4_in_ready", in_ready, 0);
    chk("bp4_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    chk("bp5_seq", seq_id, 3);
    chk("bp5_imm", imm_o, 2);
    chk("bp5_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp6_seq", seq_id, 4);
    chk("bp6_imm", imm_o, 3);
    cyc();
    chk("bp7_valid", out_valid, 0);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00400093;
    cyc();
    instr = 32'h00500093;
    cyc();
    chk("fl_full_in_ready", in_ready, 0);
    flush = 1'b1; instr = 32'h00600093;
    cyc();
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    cyc();
    chk("fl2_valid", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1; instr = 32'h00700093;
    cyc();
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_seq", seq_id, 7);
    chk("fl_after_imm", imm_o, 7);
    instr = 32'h022081B3;
    cyc();
    chk("mul_alu", alu_ctrl, 5'b10000);
    chk("mul_muldiv", is_muldiv, 1);
    chk("mul_illegal", illegal, 0);
    chk("mul_reg_write", reg_write, 3);
    chk("mul0_illegal", illegal0, 1);
    chk("mul0_reg_write", reg_write0, 0);
    chk("mul0_muldiv", is_muldiv0, 0);
    instr = 32'hFFFFFFFF;
    cyc();
    chk("ones_illegal", illegal, 1);
    chk("ones_mem_write", mem_write, 0);
    chk("ones_reg_write", reg_write, 0);
    chk("ones_branch", branch_type, 0);
    instr = 32'h0000B083;
    cyc();
    chk("ld011_illegal", illegal, 1);
    chk("ld011_reg_write", reg_write, 0);
    chk("ld011_mem_to_reg", mem_to_reg, 1);
    instr = 32'h0000C083;
    cyc();
    chk("lbu_illegal", illegal, 0);
    chk("lbu_reg_write", reg_write, 5);
    chk("lbu_mem_to_reg", mem_to_reg, 1);
    instr = 32'h00208463;
    cyc();
    chk("beq_branch", branch_type, 6);
    chk("beq_imm", imm_o, 8);
    chk("beq_imm_type", imm_type, 3);
    chk("beq_src2", alu_src2, 0);
    chk("beq_reg_write", reg_write, 0);
    instr = 32'h4030D093;
    cyc();
    chk("srai_alu", alu_ctrl, 13);
    chk("srai_src2", alu_src2, 2'b01);
    chk("srai_illegal", illegal, 0);
    chk("srai_imm", imm_o, 32'h403);
    instr = 32'h123452B7;
    cyc();
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_imm_type", imm_type, 4);
    chk("lui_alu", alu_ctrl, 9);
    chk("lui_rd", rd, 5);
    instr = 32'h010000EF;
    cyc();
    chk("jal_jal", jal, 1);
    chk("jal_npc", load_npc, 1);
    chk("jal_imm", imm_o, 16);
    chk("jal_imm_type", imm_type, 5);
    chk("jal_reg_write", reg_write, 3);
    instr = 32'h00000013; rst = 1'b1;
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_seq", seq_id, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rst = 1'b0;
    cyc();
    chk("x0_valid", out_valid, 1);
    chk("x0_seq", seq_id, 0);
    chk("x0_reg_write", reg_write, 0);
    for (int i = 0; i < 255; i++) cyc();
    chk("wrap_seq_255", seq_id, 255);
    cyc();
    in_valid = 1'b0;
    chk("wrap_seq_0", seq_id, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
